// File: rtl/mem_access_unit.sv
// mem_access_unit: MEM-stage load/store engine on an SRAM-like bus; define LLSC_EN to add the LL/SC link bit
module mem_access_unit #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_valid,
  input  logic              mem_flush,
  input  logic              wb_stall,
  input  logic [3:0]        load_type,
  input  logic [3:0]        store_type,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [31:0]       mem_wdata,
  output logic              data_req,
  output logic              data_wr,
  output logic [1:0]        data_size,
  output logic [ADDR_W-1:0] data_addr,
  output logic [3:0]        data_be,
  output logic [31:0]       data_wdata,
  input  logic              data_addr_ok,
  input  logic              data_data_ok,
  input  logic [31:0]       data_rdata,
  output logic              mem_stall,
  output logic [31:0]       load_result,
  output logic              adel,
  output logic              ades
);
  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_t;
  localparam logic [3:0] LB = 4'd1, LBU = 4'd2, LH = 4'd3, LHU = 4'd4, LW = 4'd5, LL = 4'd6;
  localparam logic [3:0] SH = 4'd2, SW = 4'd3, SC = 4'd4;
  state_t            r_state;
  logic              r_req, r_wr, r_discard, r_sc;
  logic [1:0]        r_size;
  logic [ADDR_W-1:0] r_addr;
  logic [3:0]        r_be, r_ltype;
  logic [31:0]       r_wdata, r_result;
  logic              w_ld, w_st, w_half, w_word, w_mis, w_access, w_start, w_sc, w_sc_fail, w_drop;
  logic [1:0]        w_size;
  logic [3:0]        w_be;
  logic [7:0]        w_byte;
  logic [15:0]       w_hw;
  logic [31:0]       w_wdata, w_ext, w_result;
  assign w_ld     = load_type != 4'd0;
  assign w_st     = store_type != 4'd0 && !w_ld;
  assign w_half   = (w_ld && (load_type == LH || load_type == LHU)) || (w_st && store_type == SH);
  assign w_word   = (w_ld && (load_type == LW || load_type == LL)) || (w_st && (store_type == SW || store_type == SC));
  assign w_mis    = (w_half && mem_addr[0]) || (w_word && mem_addr[1:0] != 2'b00);
  assign w_access = mem_valid && (w_ld || w_st);
  assign adel     = w_access && w_mis && w_ld;
  assign ades     = w_access && w_mis && w_st;
  assign w_start  = r_state == S_IDLE && w_access && !w_mis && !mem_flush;
  assign w_sc     = w_st && store_type == SC;
`ifdef LLSC_EN
  logic r_llbit;
  assign w_sc_fail = w_sc && !r_llbit;
`else
  assign w_sc_fail = 1'b0;
`endif
  // A failing SC resolves locally, so it is the only started access that does not stall
  assign mem_stall = (w_start && !w_sc_fail) || r_state == S_REQ || r_state == S_WAIT;
  assign w_drop    = r_discard || mem_flush;
  assign w_size    = w_word ? 2'd2 : w_half ? 2'd1 : 2'd0;
  assign w_be      = !w_st ? 4'h0 : w_word ? 4'hF : w_half ? 4'b0011 << mem_addr[1:0] : 4'b0001 << mem_addr[1:0];
  assign w_wdata   = w_word ? mem_wdata : w_half ? {2{mem_wdata[15:0]}} : {4{mem_wdata[7:0]}};
  assign w_byte    = data_rdata[{r_addr[1:0], 3'b000} +: 8];
  assign w_hw      = r_addr[1] ? data_rdata[31:16] : data_rdata[15:0];
  assign w_ext     = r_ltype == LB  ? {{24{w_byte[7]}}, w_byte} :
                     r_ltype == LBU ? {24'd0, w_byte} :
                     r_ltype == LH  ? {{16{w_hw[15]}}, w_hw} :
                     r_ltype == LHU ? {16'd0, w_hw} : data_rdata;
  assign w_result  = r_sc ? 32'd1 : r_ltype != 4'd0 ? w_ext : r_result;
  assign data_req    = r_req;
  assign data_wr     = r_wr;
  assign data_size   = r_size;
  assign data_addr   = r_addr;
  assign data_be     = r_be;
  assign data_wdata  = r_wdata;
  assign load_result = r_result;
  // Access FSM: bus fields are latched once at issue and held until the next issue
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_req     <= 1'b0;
      r_wr      <= 1'b0;
      r_size    <= 2'd0;
      r_addr    <= '0;
      r_be      <= 4'h0;
      r_wdata   <= 32'd0;
      r_result  <= 32'd0;
      r_discard <= 1'b0;
      r_sc      <= 1'b0;
      r_ltype   <= 4'd0;
    end else begin
      case (r_state)
        S_IDLE: if (w_start) begin
          if (w_sc_fail) begin
            r_state  <= S_DONE;
            r_result <= 32'd0;
          end else begin
            r_state <= S_REQ;
            r_req   <= 1'b1;
            r_wr    <= w_st;
            r_size  <= w_size;
            r_addr  <= mem_addr;
            r_be    <= w_be;
            r_wdata <= w_wdata;
            r_sc    <= w_sc;
            r_ltype <= w_ld ? load_type : 4'd0;
          end
        end
        S_REQ: begin
          if (mem_flush) r_discard <= 1'b1;
          if (data_addr_ok) begin
            r_req   <= 1'b0;
            r_state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (data_data_ok) begin
            r_state   <= w_drop ? S_IDLE : S_DONE;
            r_discard <= 1'b0;
            if (!w_drop) r_result <= w_result;
          end else if (mem_flush) r_discard <= 1'b1;
        end
        S_DONE: if (!wb_stall) r_state <= S_IDLE;
      endcase
    end
  end
`ifdef LLSC_EN
  // Link bit: set by an LL that completes undiscarded, cleared by any flush or SC outcome
  always_ff @(posedge clk) begin
    if (rst) r_llbit <= 1'b0;
    else if (mem_flush || (w_start && w_sc_fail) || (r_state == S_WAIT && data_data_ok && r_sc)) r_llbit <= 1'b0;
    else if (r_state == S_WAIT && data_data_ok && !r_discard && r_ltype == LL) r_llbit <= 1'b1;
  end
`endif
endmodule
